// File: rtl/mem_responder.sv
// mem_responder: single-port mask-based memory responder with fixed latency, byte-lane writes and protocol checks
// Optional feature macro MEM_RESP_RANDOM_STALL_EN adds 0-3 LFSR-chosen stall cycles per request.
module mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1eceb000,
    parameter int          LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              mem_addr,
    input  logic [3:0]               mem_rmask,
    input  logic [3:0]               mem_wmask,
    input  logic [31:0]              mem_wdata,
    output logic [31:0]              mem_rdata,
    output logic                     mem_resp,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_idx,
    input  logic [31:0]              init_wdata,
    output logic                     err_oob,
    output logic                     err_proto
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 4);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [3:0]    r_rmask, r_wmask;
    logic [AW-1:0] r_idx;
    logic          r_oob, r_wr, r_resp, r_err_oob, r_err_proto;
    logic [31:0]   r_mem [DEPTH];
    logic          w_req, w_oob, w_changed;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic [CW-1:0] w_extra, w_load;
    assign w_req     = |(mem_rmask | mem_wmask);
    assign w_offset  = {mem_addr[31:2], 2'b00} - BASE_ADDR;
    assign w_idx     = w_offset[2 +: AW];
    assign w_oob     = w_offset >= 32'(4 * DEPTH);
    assign w_load    = CW'(LATENCY - 1) + w_extra;
    assign w_changed = (mem_addr != r_addr) || (mem_rmask != r_rmask) ||
                       (mem_wmask != r_wmask) || (mem_wdata != r_wdata);
`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;
    // Free-running Fibonacci LFSR (taps 16,14,13,11) choosing the extra stall per request
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_extra = CW'(r_lfsr[1:0]);
`else
    assign w_extra = '0;
`endif
    // Request FSM: capture on accept, count down latency, pulse mem_resp with data for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_resp      <= 1'b0;
            r_rdata     <= '0;
            r_err_oob   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: if (w_req) begin
                    r_addr  <= mem_addr;
                    r_rmask <= mem_rmask;
                    r_wmask <= mem_wmask;
                    r_wdata <= mem_wdata;
                    r_idx   <= w_idx;
                    r_oob   <= w_oob;
                    r_wr    <= mem_rmask == 4'h0;
                    r_cnt   <= w_load;
                    if (w_oob) r_err_oob <= 1'b1;
                    if ((|mem_rmask && |mem_wmask) || |mem_addr[1:0]) r_err_proto <= 1'b1;
                    if (w_load == '0) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (|mem_rmask) r_rdata <= w_oob ? 32'h0 : r_mem[w_idx];
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_changed) r_err_proto <= 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (!r_wr) r_rdata <= r_oob ? 32'h0 : r_mem[r_idx];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Backdoor preload and port write; the port write comes last so it wins on its masked lanes
    always_ff @(posedge clk) begin
        if (init_we) r_mem[init_idx] <= init_wdata;
        if (!rst && r_state == RESP && r_wr && !r_oob)
            for (int i = 0; i < 4; i++)
                if (r_wmask[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
    end
    assign mem_resp  = r_resp;
    assign mem_rdata = r_rdata;
    assign err_oob   = r_err_oob;
    assign err_proto = r_err_proto;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table, corner-case sequences and random traffic against an array model
module tb_mem_responder;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1eceb000;
    localparam int          LAT   = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata, init_wdata = '0;
    logic [3:0]  mem_rmask = '0, mem_wmask = '0;
    logic        mem_resp, init_we = 1'b0, err_oob, err_proto;
    logic [9:0]  init_idx = '0;
    int          n_vec = 0, n_err = 0;
    typedef struct {
        logic [31:0] a;
        logic [3:0]  rm, wm;
        logic [31:0] wd, exp;
    } vec_t;
    vec_t        tbl[11];
    logic [31:0] mdl[16];
    mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .init_we(init_we),
        .init_idx(init_idx), .init_wdata(init_wdata), .err_oob(err_oob), .err_proto(err_proto)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bd(input int idx, input logic [31:0] d);
        @(negedge clk);
        init_we = 1'b1; init_idx = 10'(idx); init_wdata = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1; mem_rmask = '0; mem_wmask = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one request in an idle cycle, wait (bounded) for mem_resp, check the latency
    task automatic req(input string name, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input bit hold, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        mem_addr = a; mem_rmask = rm; mem_wmask = wm; mem_wdata = wd;
        lat = 0; rd = '0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_resp) begin
                lat = k;
                rd = mem_rdata;
            end
        end
        chk({name, " latency"}, lat, LAT);
        if (hold) begin
            @(negedge clk);
            chk({name, " pulse width"}, {31'h0, mem_resp}, 32'h0);
        end
        mem_rmask = '0; mem_wmask = '0;
    endtask

    initial begin
        logic [31:0] rd, d;
        logic [3:0]  m;
        int          idx, cnt;
        tbl[0]  = '{32'h1eceb000, 4'hF, 4'h0, 32'h0,        32'h00000013};
        tbl[1]  = '{32'h1eceb004, 4'h0, 4'h4, 32'h00AB0000, 32'h00000013};
        tbl[2]  = '{32'h1eceb004, 4'hF, 4'h0, 32'h0,        32'h11AB3344};
        tbl[3]  = '{32'h1eceb004, 4'h1, 4'h0, 32'h0,        32'h11AB3344};
        tbl[4]  = '{32'h1eceb008, 4'h0, 4'h3, 32'h0000BEEF, 32'h11AB3344};
        tbl[5]  = '{32'h1eceb008, 4'hF, 4'h0, 32'h0,        32'hCAFEBEEF};
        tbl[6]  = '{32'h1eceb00C, 4'h0, 4'hF, 32'h12345678, 32'hCAFEBEEF};
        tbl[7]  = '{32'h1eceb00C, 4'hF, 4'h0, 32'h0,        32'h12345678};
        tbl[8]  = '{32'h1eceb00C, 4'h0, 4'h8, 32'hAA000000, 32'h12345678};
        tbl[9]  = '{32'h1eceb00C, 4'h2, 4'h0, 32'h0,        32'hAA345678};
        tbl[10] = '{32'h1ecebffc, 4'hF, 4'h0, 32'h0,        32'h5A5A5A5A};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset mem_resp", {31'h0, mem_resp}, 32'h0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        chk("reset err_oob", {31'h0, err_oob}, 32'h0);
        chk("reset err_proto", {31'h0, err_proto}, 32'h0);
        bd(0, 32'h00000013); bd(1, 32'h11223344); bd(2, 32'hCAFEF00D);
        bd(3, 32'h0); bd(4, 32'h0); bd(5, 32'h0); bd(1023, 32'h5A5A5A5A);
        req("first read", BASE, 4'hF, 4'h0, 32'h0, 1'b1, rd);
        chk("first read data", rd, 32'h00000013);
        cnt = 0;
        repeat (4) begin @(negedge clk); cnt += int'(mem_resp); end
        chk("held request not re-accepted", cnt, 0);
        for (int i = 0; i < 11; i++) begin
            req($sformatf("vec%0d", i), tbl[i].a, tbl[i].rm, tbl[i].wm, tbl[i].wd, 1'b0, rd);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp);
        end
        chk("table err_oob", {31'h0, err_oob}, 32'h0);
        chk("table err_proto", {31'h0, err_proto}, 32'h0);
        req("collide wr", 32'h1eceb014, 4'h0, 4'h3, 32'h00001111, 1'b0, rd);
        init_we = 1'b1; init_idx = 10'd5; init_wdata = 32'hAABBCCDD;
        @(negedge clk);
        init_we = 1'b0;
        req("collide rd", 32'h1eceb014, 4'hF, 4'h0, 32'h0, 1'b0, rd);
        chk("collide merge", rd, 32'hAABB1111);
        req("oob rd", 32'h0, 4'hF, 4'h0, 32'h0, 1'b0, rd);
        chk("oob rdata", rd, 32'h0);
        chk("oob err_oob", {31'h0, err_oob}, 32'h1);
        chk("oob err_proto", {31'h0, err_proto}, 32'h0);
        req("oob wr", BASE + 32'h1000, 4'h0, 4'hF, 32'hFFFFFFFF, 1'b0, rd);
        req("after oob wr", BASE, 4'hF, 4'h0, 32'h0, 1'b0, rd);
        chk("oob write dropped", rd, 32'h00000013);
        chk("err_oob sticky", {31'h0, err_oob}, 32'h1);
        do_rst();
        chk("err_oob cleared", {31'h0, err_oob}, 32'h0);
        req("both masks", 32'h1eceb010, 4'hF, 4'h1, 32'hFFFFFFFF, 1'b0, rd);
        chk("both masks rdata", rd, 32'h0);
        chk("both masks err_proto", {31'h0, err_proto}, 32'h1);
        req("both masks check", 32'h1eceb010, 4'hF, 4'h0, 32'h0, 1'b0, rd);
        chk("both masks no write", rd, 32'h0);
        do_rst();
        req("misaligned", 32'h1eceb001, 4'hF, 4'h0, 32'h0, 1'b0, rd);
        chk("misaligned rdata", rd, 32'h00000013);
        chk("misaligned err_proto", {31'h0, err_proto}, 32'h1);
        chk("misaligned err_oob", {31'h0, err_oob}, 32'h0);
        do_rst();
        @(negedge clk);
        mem_addr = BASE; mem_rmask = 4'hF;
        @(negedge clk);
        mem_addr = 32'h1eceb008;
        @(negedge clk);
        chk("addr change resp", {31'h0, mem_resp}, 32'h1);
        chk("addr change rdata", mem_rdata, 32'h00000013);
        chk("addr change err_proto", {31'h0, err_proto}, 32'h1);
        mem_rmask = '0;
        @(negedge clk);
        mem_addr = 32'h1eceb008; mem_wmask = 4'hF; mem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid-wait resp", {31'h0, mem_resp}, 32'h0);
        chk("rst mid-wait rdata", mem_rdata, 32'h0);
        chk("rst mid-wait err_proto", {31'h0, err_proto}, 32'h0);
        chk("rst mid-wait err_oob", {31'h0, err_oob}, 32'h0);
        rst = 1'b0; mem_wmask = '0;
        cnt = 0;
        repeat (4) begin @(negedge clk); cnt += int'(mem_resp); end
        chk("rst mid-wait no resp", cnt, 0);
        req("rst mid-wait readback", 32'h1eceb008, 4'hF, 4'h0, 32'h0, 1'b0, rd);
        chk("rst mid-wait word kept", rd, 32'hCAFEBEEF);
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            bd(i, mdl[i]);
        end
        for (int t = 0; t < 150; t++) begin
            idx = $urandom_range(0, 15);
            d = $urandom;
            m = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) begin
                mdl[idx] = d;
                bd(idx, d);
            end else if ($urandom_range(0, 1) == 1) begin
                req("rand wr", BASE + 32'(4 * idx), 4'h0, m, d, 1'b0, rd);
                for (int b = 0; b < 4; b++)
                    if (m[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                req("rand rd", BASE + 32'(4 * idx), m, 4'h0, d, 1'b0, rd);
                chk($sformatf("rand rd idx%0d", idx), rd, mdl[idx]);
            end
        end
        chk("rand err_oob", {31'h0, err_oob}, 32'h0);
        chk("rand err_proto", {31'h0, err_proto}, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the CPU's single-port mask-based memory interface: mem_addr, mem_rmask, mem_wmask, mem_wdata, mem_rdata, mem_resp.
- Accepts one read or write request at a time and applies a fixed response latency.
- Backed by an internal word array with byte-lane writes.
- Checks protocol rules, and sits between the CPU and the testbench/top-level in place of a behavioural memory model.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of two, >=4).
- BASE_ADDR, 32'h1eceb000, byte address of word 0 (CPU reset PC).
- LATENCY, 2, cycles from request acceptance to mem_resp (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- mem_addr  input  32  request byte address, word-aligned.
- mem_rmask  input  4  read byte mask; nonzero = read request.
- mem_wmask  input  4  write byte mask; nonzero = write request.
- mem_wdata  input  32  write data, lane-aligned.
- mem_rdata  output  32  read data, valid when mem_resp=1.
- mem_resp  output  1  one-cycle completion pulse.
- init_we  input  1  backdoor word write (program preload).
- init_idx  input  $clog2(DEPTH)  backdoor word index.
- init_wdata  input  32  backdoor word data.
- err_oob  output  1  sticky: request address outside the array.
- err_proto  output  1  sticky: rmask and wmask both nonzero, addr[1:0]!=0, or request changed while pending.

Behaviour:
- One clock: clk. Reset: rst, synchronous, active-high.
- Reset values: mem_resp=0, mem_rdata=0, err_oob=0, err_proto=0, state IDLE, counter 0. Array contents are not reset and are retained across rst.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a cycle where (mem_rmask|mem_wmask)!=0, capture addr, rmask, wmask and wdata; load counter=LATENCY-1; go to WAIT. If LATENCY==1, go directly to RESP.
- WAIT: decrement the counter each cycle; at 0 go to RESP.
- Pending request checks: captured fields are compared each WAIT cycle against the live inputs. Any mismatch sets err_proto. The captured copy is still used.
- RESP: mem_resp is registered and high for exactly this cycle.
  - Reads: mem_rdata = full stored word. The CPU extracts lanes itself; unmasked lanes are returned too.
  - Writes: the byte lanes with wmask[i]=1 update at the clock edge ending RESP; mem_rdata holds its previous value.
  - Next state is IDLE unconditionally. The request still visible during RESP is never re-accepted.
- Timing: request first sampled at edge t, mem_resp high in cycle t+LATENCY. The next request is acceptable at edge t+LATENCY+1, so back-to-back throughput is one transaction per LATENCY+1 cycles.
- Address decode: offset = mem_addr - BASE_ADDR (32-bit wraparound); index = offset[2+:log2(DEPTH)].
  - In range iff offset < 4*DEPTH.
  - Out of range: err_oob set at acceptance; reads return 32'h0; writes are dropped; mem_resp is still given.
- Protocol errors at acceptance: rmask!=0 && wmask!=0 sets err_proto and the request is treated as a read only. addr[1:0]!=0 sets err_proto and the address is used with [1:0] forced to 0.
- Read-after-write: a read accepted after a write's RESP returns the updated bytes.
- Backdoor writes: init_we writes a full word at any time. If it hits the same index in the same cycle as a RESP write, the port write wins per masked lane and init wins for the other lanes.
- Reset mid-transaction: the pending request is discarded, no array write occurs, and mem_resp stays 0.
- Sticky errors clear only on rst.

Optional Feature:
- MEM_RESP_RANDOM_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle. At acceptance, LFSR[1:0] extra cycles (0-3) are added to the counter, so the latency is LATENCY..LATENCY+3. All other rules are unchanged.
- Undefined: latency is exactly LATENCY, and no LFSR is instantiated.

Test Plan:
- Preload via init idx 0 = 32'h00000013. Read at addr 1eceb000, rmask 4'hF, LATENCY=2 -> mem_resp high exactly 2 cycles after acceptance, mem_rdata=32'h00000013, single-cycle pulse.
- Write 1eceb004 wmask 4'b0100 wdata 32'h00AB0000 over preload 32'h11223344, then read 1eceb004 -> 32'h11AB3344.
- Hold the read request steady through RESP, then drop it -> exactly one mem_resp. A new request the cycle after RESP is accepted immediately.
- Read at 32'h00000000 -> err_oob=1, mem_rdata=0, mem_resp still asserted. err_oob stays 1 until rst.
- Assert rmask=4'hF and wmask=4'h1 together; separately change mem_addr mid-WAIT -> err_proto=1 in both cases, and no array write occurs in the first case.
- Assert rst during WAIT of a write of 32'hDEADBEEF to 1eceb008 -> no mem_resp, word at idx 2 unchanged, outputs return to reset values.
